// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter with a burst quantum in front of a single-port memory.
// Memory controls are registered one cycle after accept; read data returns two cycles after accept.
module mem_port_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int MEMORY_DEPTH = 1024,
  parameter int MAX_BURST    = 4,
  localparam int AW = $clog2(MEMORY_DEPTH)
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  r0_valid,
  output logic                  r0_ready,
  input  logic                  r0_we,
  input  logic [AW-1:0]         r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_rvalid,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  input  logic                  r1_valid,
  output logic                  r1_ready,
  input  logic                  r1_we,
  input  logic [AW-1:0]         r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_rvalid,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [AW-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t          state, state_nxt;
  logic            last_owner, last_nxt;
  logic [BW-1:0]   burst_cnt, cnt_nxt;
  logic            grant_vld, grant_id;
  logic            quantum_done;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic            rd1_vld, rd1_id, rd2_vld, rd2_id;

  assign quantum_done = (burst_cnt == BW'(MAX_BURST));

  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    state_nxt = IDLE;
    last_nxt  = last_owner;
    cnt_nxt   = '0;
    case (state)
      IDLE: begin
        if (r0_valid && r1_valid) begin
          grant_vld = 1'b1;
          grant_id  = ~last_owner;
        end else if (r0_valid || r1_valid) begin
          grant_vld = 1'b1;
          grant_id  = r1_valid;
        end
      end
      OWN0: begin
        if (r1_valid && (!r0_valid || quantum_done)) begin
          grant_vld = 1'b1;
          grant_id  = 1'b1;
        end else if (r0_valid) begin
          grant_vld = 1'b1;
          grant_id  = 1'b0;
        end
      end
      OWN1: begin
        if (r0_valid && (!r1_valid || quantum_done)) begin
          grant_vld = 1'b1;
          grant_id  = 1'b0;
        end else if (r1_valid) begin
          grant_vld = 1'b1;
          grant_id  = 1'b1;
        end
      end
      default: ;
    endcase
    if (ARESET) grant_vld = 1'b0;

    if (grant_vld) begin
      state_nxt = grant_id ? OWN1 : OWN0;
      last_nxt  = grant_id;
      // Quantum restarts whenever ownership is (re)acquired.
      if (state == IDLE || (state == OWN1) != grant_id)
        cnt_nxt = BW'(1);
      else if (!quantum_done)
        cnt_nxt = burst_cnt + 1'b1;
      else
        cnt_nxt = burst_cnt;
    end
  end

  assign r0_ready  = grant_vld & ~grant_id;
  assign r1_ready  = grant_vld & grant_id;
  assign sel_we    = grant_id ? r1_we    : r0_we;
  assign sel_addr  = grant_id ? r1_addr  : r0_addr;
  assign sel_wdata = grant_id ? r1_wdata : r0_wdata;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      burst_cnt  <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rd1_vld    <= 1'b0;
      rd1_id     <= 1'b0;
      rd2_vld    <= 1'b0;
      rd2_id     <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_owner <= last_nxt;
      burst_cnt  <= cnt_nxt;
      mem_en     <= grant_vld;
      mem_we     <= grant_vld & sel_we;
      if (grant_vld) begin
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
      end
      // Read tag follows the op through the memory's one-cycle read latency.
      rd1_vld <= grant_vld & ~sel_we;
      rd1_id  <= grant_id;
      rd2_vld <= rd1_vld;
      rd2_id  <= rd1_id;
    end
  end

  assign r0_rvalid = rd2_vld & ~rd2_id;
  assign r1_rvalid = rd2_vld & rd2_id;
  assign r0_rdata  = mem_rdata;
  assign r1_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter with a behavioural memory and arbitration model.
module tb_mem_port_arbiter;
  localparam int DW = 32;
  localparam int DEPTH = 1024;
  localparam int AW = 10;
  localparam int MAXB = 4;

  logic ACLK = 1'b0;
  logic ARESET;
  logic r0_valid, r0_ready, r0_we, r0_rvalid;
  logic r1_valid, r1_ready, r1_we, r1_rvalid;
  logic [AW-1:0] r0_addr, r1_addr, mem_addr;
  logic [DW-1:0] r0_wdata, r1_wdata, r0_rdata, r1_rdata, mem_wdata, mem_rdata;
  logic mem_en, mem_we;

  mem_port_arbiter #(.DATA_WIDTH(DW), .MEMORY_DEPTH(DEPTH), .MAX_BURST(MAXB)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 ACLK = ~ACLK;

  // Synchronous single-port RAM: read data appears the cycle after the read is sampled.
  logic [DW-1:0] mem_arr [DEPTH];
  always @(posedge ACLK) begin
    if (mem_en) begin
      if (mem_we) mem_arr[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem_arr[mem_addr];
    end
  end

  typedef struct { int cyc; bit we; bit [AW-1:0] addr; bit [DW-1:0] data; } op_t;
  typedef struct { int cyc; bit id; bit [DW-1:0] data; } rd_t;
  op_t opq[$];
  rd_t rdq[$];
  bit [DW-1:0] shadow [DEPTH];

  int n_chk = 0, n_fail = 0, cyc = 0;
  int prev = -1, last = 1, run = 0;
  bit prev_rst = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(posedge ACLK) cyc++;

  // Monitor: compares readies against the model and pops the scoreboard on DUT outputs.
  always @(negedge ACLK) begin
    int g;
    op_t o;
    rd_t r;
    bit [AW-1:0] a;
    if (ARESET) g = -1;
    else if (r0_valid && r1_valid) begin
      if (prev < 0) g = 1 - last;
      else if (run < MAXB) g = prev;
      else g = 1 - prev;
    end else if (r0_valid) g = 0;
    else if (r1_valid) g = 1;
    else g = -1;

    chk("ready", {r1_ready, r0_ready}, (g < 0) ? 2'b00 : (g == 1) ? 2'b10 : 2'b01);

    if (prev_rst && !ARESET) begin
      chk("post_reset_mem", {mem_en, mem_we, mem_addr, mem_wdata}, '0);
      chk("post_reset_rvalid", {r1_rvalid, r0_rvalid}, 2'b00);
    end

    if (mem_en) begin
      if (opq.size() == 0) chk("unexpected_mem_en", 1, 0);
      else begin
        o = opq.pop_front();
        chk("op_cycle", cyc, o.cyc);
        chk("op_fields", {mem_we, mem_addr, mem_wdata}, {o.we, o.addr, o.data});
      end
    end else begin
      chk("idle_mem_we", mem_we, 0);
      if (opq.size() > 0 && opq[0].cyc <= cyc) begin
        chk("missing_mem_op", 0, 1);
        void'(opq.pop_front());
      end
    end

    if (r0_rvalid || r1_rvalid) begin
      chk("rvalid_exclusive", r0_rvalid & r1_rvalid, 0);
      if (rdq.size() == 0) chk("unexpected_rvalid", 1, 0);
      else begin
        r = rdq.pop_front();
        chk("rd_cycle", cyc, r.cyc);
        chk("rd_route", {r1_rvalid, r0_rvalid}, r.id ? 2'b10 : 2'b01);
        chk("rd_data", r.id ? r1_rdata : r0_rdata, r.data);
      end
    end else if (rdq.size() > 0 && rdq[0].cyc <= cyc) begin
      chk("missing_rvalid", 0, 1);
      void'(rdq.pop_front());
    end

    if (g >= 0) begin
      o.cyc  = cyc + 1;
      o.we   = (g == 1) ? r1_we : r0_we;
      a      = (g == 1) ? r1_addr : r0_addr;
      o.addr = a;
      o.data = (g == 1) ? r1_wdata : r0_wdata;
      opq.push_back(o);
      if (o.we) shadow[a] = o.data;
      else begin
        r.cyc = cyc + 2; r.id = g[0]; r.data = shadow[a];
        rdq.push_back(r);
      end
      run  = (g == prev) ? run + 1 : 1;
      prev = g;
      last = g;
    end else begin
      prev = -1;
      run  = 0;
    end

    if (ARESET) begin
      while (opq.size() > 0 && opq[$].cyc > cyc) void'(opq.pop_back());
      while (rdq.size() > 0 && rdq[$].cyc > cyc) void'(rdq.pop_back());
      prev = -1; last = 1; run = 0;
    end
    prev_rst = ARESET;
  end

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic drive(input bit v0, input bit w0, input int a0, input bit [DW-1:0] d0,
                       input bit v1, input bit w1, input int a1, input bit [DW-1:0] d1);
    r0_valid = v0; r0_we = w0; r0_addr = AW'(a0); r0_wdata = d0;
    r1_valid = v1; r1_we = w1; r1_addr = AW'(a1); r1_wdata = d1;
    step();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_arr[i] = '0;
      shadow[i]  = '0;
    end
    mem_rdata = '0;
    ARESET = 1'b1;
    drive(1, 0, 1, 0, 1, 0, 2, 0);
    drive(1, 0, 1, 0, 1, 0, 2, 0);
    ARESET = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // Write then read back the same address from r0.
    drive(1, 1, 'h005, 32'hDEADBEEF, 0, 0, 0, 0);
    drive(1, 0, 'h005, 0, 0, 0, 0, 0);
    repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 0);

    // Sustained contention exercises the burst quantum.
    for (int i = 0; i < 20; i++)
      drive(1, $urandom_range(0, 1), $urandom_range(0, 15), $urandom,
            1, $urandom_range(0, 1), $urandom_range(0, 15), $urandom);
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // Tie after idle goes to the requester not served last.
    drive(1, 0, 3, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 3, 0, 1, 0, 4, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // Back-to-back reads from alternating requesters.
    drive(1, 1, 'h010, 32'h11111111, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 1, 'h020, 32'h22222222);
    drive(1, 0, 'h010, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 'h020, 0);
    repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset lands while a read is in flight.
    drive(1, 0, 'h010, 0, 0, 0, 0, 0);
    ARESET = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    ARESET = 1'b0;
    repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      ARESET = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 15), $urandom,
            $urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 15), $urandom);
    end
    ARESET = 1'b0;
    repeat (6) drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("opq_drained", opq.size(), 0);
    chk("rdq_drained", rdq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port memory (mem_en/mem_we/mem_addr/mem_wdata/mem_rdata) between two requesters, e.g. the AXI4 slave's write-channel and read-channel engines.
- Arbitrates round-robin with a burst quantum and drives registered memory controls.
- Routes read data back to the requester that issued the read.
- Fully pipelined: accepts at most one request per cycle.

Parameters:
- DATA_WIDTH, 32, memory word width
- MEMORY_DEPTH, 1024, memory words; AW = $clog2(MEMORY_DEPTH)
- MAX_BURST, 4, maximum consecutive accepts for one owner while the other requester is waiting (>=1)

Ports:
- ACLK  in  1  clock, all logic on rising edge
- ARESET  in  1  synchronous, active-high reset
- r0_valid  in  1  requester 0 request valid
- r0_ready  out  1  requester 0 accepted this cycle
- r0_we  in  1  1=write, 0=read
- r0_addr  in  AW  word address
- r0_wdata  in  DATA_WIDTH  write data
- r0_rvalid  out  1  read data valid for requester 0
- r0_rdata  out  DATA_WIDTH  read data (= mem_rdata)
- r1_valid, r1_ready, r1_we, r1_addr, r1_wdata, r1_rvalid, r1_rdata: same as r0_*, for requester 1
- mem_en  out  1  memory enable (registered)
- mem_we  out  1  memory write enable (registered)
- mem_addr  out  AW  memory address (registered)
- mem_wdata  out  DATA_WIDTH  memory write data (registered)
- mem_rdata  in  DATA_WIDTH  memory read data, valid the cycle after mem_en&!mem_we is sampled

Behaviour:
- Handshake: request i is accepted when ri_valid & ri_ready are high at a rising edge.
  - ri_ready is combinational from state, burst_cnt, r0_valid, r1_valid.
  - At most one ready is high per cycle; ready is never high without the matching valid.
- FSM states: IDLE, OWN0, OWN1; also last_owner (1 bit) and burst_cnt (0..MAX_BURST).
- Selection, computed each cycle:
  - IDLE: both valid -> grant !last_owner; else grant whichever is valid; none valid -> no grant.
  - OWNx, other requester valid and (rx_valid==0 or burst_cnt==MAX_BURST) -> grant other.
  - OWNx, otherwise, rx_valid -> grant x.
  - OWNx, neither valid -> no grant.
- Next state:
  - Grant to x -> OWNx, last_owner<=x.
  - burst_cnt<=1 on an owner change or when leaving IDLE; else burst_cnt<=min(burst_cnt+1, MAX_BURST).
  - No grant -> IDLE, burst_cnt<=0; last_owner holds.
- Memory issue:
  - On accept in cycle C, in cycle C+1: mem_en=1, mem_we=ri_we, mem_addr=ri_addr, mem_wdata=ri_wdata.
  - No accept -> mem_en=0, mem_we=0; mem_addr and mem_wdata hold their last values.
- Read return:
  - A read accepted in cycle C raises ri_rvalid for exactly one cycle, C+2.
  - ri_rdata = mem_rdata (combinational passthrough, valid only with rvalid).
  - Tracked by a 2-stage {valid, id} pipeline.
  - Writes produce no rvalid. r0_rvalid and r1_rvalid are never high together.
- Ordering:
  - Memory ops execute in accept order.
  - A read accepted the cycle after a write to the same address returns the new data; the memory's registered write already meets this.
- Throughput: 1 accept/cycle sustained, including alternating owners and read/write mixes.
- Reset (ARESET high at an edge):
  - State<=IDLE, last_owner<=1 (r0 wins the first tie), burst_cnt<=0.
  - mem_en, mem_we, mem_addr, mem_wdata <=0.
  - Return pipeline cleared: r0_rvalid=r1_rvalid=0.
  - r0_ready=r1_ready=0 while ARESET is high.
- Reset mid-operation: reads accepted before reset never produce rvalid, and no memory op is issued in the cycle after reset deasserts unless that cycle's accept occurs.
- MAX_BURST=1 degenerates to strict alternation under contention.

Test Plan:
- Reset: ARESET=1 for 2 cycles with r0_valid=r1_valid=1 -> r0_ready=r1_ready=0, mem_en=0, mem_addr=0, rvalid=0; first tie after reset granted to r0.
- Write/read r0: write addr 0x005 data 0xDEADBEEF accepted cycle C, read 0x005 accepted C+1 -> mem_en/mem_we=1/1 in C+1 and 1/0 in C+2; r0_rvalid=1, r0_rdata=0xDEADBEEF in C+3; r1_rvalid stays 0.
- Contention, MAX_BURST=4, both valid continuously -> accept sequence r0,r0,r0,r0,r1,r1,r1,r1,r0…; exactly one ready per cycle, mem_en=1 every cycle.
- Tie rotation after idle: r0 served, one idle cycle, then both valid -> r1 granted first.
- Alternating reads: r0 reads 0x010 (holding 0x11111111), r1 reads 0x020 (holding 0x22222222) on consecutive cycles -> r0_rvalid with 0x11111111, then r1_rvalid with 0x22222222 the next cycle; no cross-routing.
- Reset mid-read: read accepted in C, ARESET=1 in C+1 -> no rvalid in C+2 or C+3; mem_en=0 after reset.
